batch_dist_control_unit: RTL and testbench

Sequencer for the distance datapath that computes Euclidean distances for a batch of vectors in one run. It walks each vector in PIPE_WIDTH-element chunks, drives the pipe, accumulator and square-root handshakes, and writes one result per vector. It sits between the vector BRAM/pipes and the accumulator/sqrt units, and replaces the single-vector controller.

---
 rtl/batch_dist_control_unit.sv | 136 +++++++++++++
 tb/tb_batch_dist_control_unit.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/batch_dist_control_unit.sv
// batch_dist_control_unit: sequences chunked distance computation for a batch of vectors.
// Optional watchdog abort enabled by defining DIST_TIMEOUT_EN.
module batch_dist_control_unit #(
    parameter int PIPE_WIDTH  = 16,
    parameter int ADD_WIDTH   = 10,
    parameter int VEC_WIDTH_W = 8,
    parameter int NVEC_W      = 8
) (
    input  logic                   clk,
    input  logic                   RST,
    input  logic                   START,
    input  logic [VEC_WIDTH_W-1:0] VECTOR_WIDTH,
    input  logic [NVEC_W-1:0]      NUM_VECTORS,
    input  logic                   RDY_Acc,
    input  logic                   RDY_Sqrt,
    output logic [PIPE_WIDTH-1:0]  EN_Pipe,
    output logic [ADD_WIDTH-1:0]   ADDR_RAM,
    output logic                   EN_Acc,
    output logic                   RST_Acc,
    output logic                   PRE_Acc,
    output logic                   RST_P,
    output logic                   EN_Sqrt,
    output logic                   RST_Sqrt,
    output logic                   WE_RES,
    output logic [NVEC_W-1:0]      ADDR_RES,
    output logic                   BUSY,
    output logic                   DONE,
    output logic                   ERR
);
    typedef enum logic [2:0] {
        IDLE, HARD_RESET, WAIT_ACC, SOFT_RESET, SQRT_WAIT, WRITE, FINISH
    } state_t;
    localparam logic [VEC_WIDTH_W:0] PW = (VEC_WIDTH_W+1)'(PIPE_WIDTH);
    state_t                 state_q, state_d;
    logic [VEC_WIDTH_W-1:0] vw_q, vw_d;
    logic [NVEC_W-1:0]      nv_q, nv_d, vec_q, vec_d;
    logic [ADD_WIDTH-1:0]   base_q, base_d;
    logic [VEC_WIDTH_W:0]   off_q, off_d, rem;
    logic                   last_chunk, busy;
`ifdef DIST_TIMEOUT_EN
    logic [7:0] wd_q, wd_d;
    logic       err_q, err_d, waiting, abort;
`endif
    assign rem        = {1'b0, vw_q} - off_q;
    assign last_chunk = rem <= PW;
    assign busy       = state_q != IDLE;
    // Counters keep their last values after a batch, so gate the datapath outputs in IDLE.
    assign ADDR_RAM = busy ? base_q + ADD_WIDTH'(off_q) : '0;
    assign EN_Pipe  = !busy ? '0 : rem >= PW ? '1 : (PIPE_WIDTH'(1) << rem) - PIPE_WIDTH'(1);
    assign EN_Acc   = state_q == HARD_RESET || state_q == WAIT_ACC || state_q == SOFT_RESET;
    assign RST_Acc  = state_q == HARD_RESET || state_q == SOFT_RESET;
    assign RST_P    = RST_Acc;
    assign PRE_Acc  = state_q == SOFT_RESET;
    assign EN_Sqrt  = state_q == SQRT_WAIT;
    assign RST_Sqrt = state_q == IDLE || state_q == HARD_RESET;
    assign WE_RES   = state_q == WRITE;
    assign ADDR_RES = WE_RES ? vec_q : '0;
    assign BUSY     = busy;
    assign DONE     = state_q == FINISH;
    always_comb begin
        state_d = state_q;
        vw_d    = vw_q;
        nv_d    = nv_q;
        vec_d   = vec_q;
        base_d  = base_q;
        off_d   = off_q;
        case (state_q)
            IDLE: if (START) begin
                if (VECTOR_WIDTH == '0 || NUM_VECTORS == '0) state_d = FINISH;
                else begin
                    state_d = HARD_RESET;
                    vw_d    = VECTOR_WIDTH;
                    nv_d    = NUM_VECTORS;
                    vec_d   = '0;
                    base_d  = '0;
                    off_d   = '0;
                end
            end
            HARD_RESET: begin
                off_d   = '0;
                state_d = WAIT_ACC;
            end
            WAIT_ACC:   if (RDY_Acc) state_d = last_chunk ? SQRT_WAIT : SOFT_RESET;
            SOFT_RESET: begin
                off_d   = off_q + PW;
                state_d = WAIT_ACC;
            end
            SQRT_WAIT:  if (RDY_Sqrt) state_d = WRITE;
            WRITE: if (vec_q == nv_q - NVEC_W'(1)) state_d = FINISH;
            else begin
                vec_d   = vec_q + NVEC_W'(1);
                base_d  = base_q + ADD_WIDTH'(vw_q);
                state_d = HARD_RESET;
            end
            default: state_d = IDLE;
        endcase
`ifdef DIST_TIMEOUT_EN
        waiting = state_q == WAIT_ACC || state_q == SQRT_WAIT;
        abort   = waiting && state_d == state_q && wd_q == 8'd254;
        if (abort) state_d = FINISH;
        err_d   = (state_q == IDLE && START) ? 1'b0 : err_q | abort;
        wd_d    = (waiting && state_d == state_q) ? wd_q + 8'd1 : 8'd0;
`endif
    end
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q <= IDLE;
            vw_q    <= '0;
            nv_q    <= '0;
            vec_q   <= '0;
            base_q  <= '0;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            vw_q    <= vw_d;
            nv_q    <= nv_d;
            vec_q   <= vec_d;
            base_q  <= base_d;
            off_q   <= off_d;
        end
    end
`ifdef DIST_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (RST) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end
    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif
endmodule

// File: tb/tb_batch_dist_control_unit.sv
// tb_batch_dist_control_unit: directed batch scenarios with hand-computed addresses, enables and strobes.
module tb_batch_dist_control_unit;
    logic        clk = 1'b0;
    logic        RST, START, RDY_Acc, RDY_Sqrt;
    logic [7:0]  VECTOR_WIDTH, NUM_VECTORS;
    logic [15:0] EN_Pipe;
    logic [9:0]  ADDR_RAM;
    logic        EN_Acc, RST_Acc, PRE_Acc, RST_P, EN_Sqrt, RST_Sqrt, WE_RES, BUSY, DONE, ERR;
    logic [7:0]  ADDR_RES;
    int          n_chk = 0, n_pass = 0;
    logic [15:0] addrs[$], ens[$];
    int          wrs[$];
    int          accs, cyc_done, wa_n;
    logic        err_seen;
    logic [15:0] ea[3], ee[3];
    always #5 clk = ~clk;
    batch_dist_control_unit dut (
        .clk(clk), .RST(RST), .START(START), .VECTOR_WIDTH(VECTOR_WIDTH), .NUM_VECTORS(NUM_VECTORS),
        .RDY_Acc(RDY_Acc), .RDY_Sqrt(RDY_Sqrt), .EN_Pipe(EN_Pipe), .ADDR_RAM(ADDR_RAM),
        .EN_Acc(EN_Acc), .RST_Acc(RST_Acc), .PRE_Acc(PRE_Acc), .RST_P(RST_P),
        .EN_Sqrt(EN_Sqrt), .RST_Sqrt(RST_Sqrt), .WE_RES(WE_RES), .ADDR_RES(ADDR_RES),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(BUSY), 0);
        chk({tag, "_outs"}, {EN_Pipe, ADDR_RAM, EN_Acc, RST_Acc, PRE_Acc, RST_P, EN_Sqrt, WE_RES, DONE}, 0);
        chk({tag, "_addr_res"}, 32'(ADDR_RES), 0);
        chk({tag, "_rst_sqrt"}, 32'(RST_Sqrt), 1);
    endtask
    // Pulse START, then log WAIT_ACC addresses, writes and the DONE cycle (1 = first cycle after START).
    task automatic run(input logic [7:0] vw, input logic [7:0] nv, input bit pert);
        addrs.delete(); ens.delete(); wrs.delete();
        accs = 0; cyc_done = 0; wa_n = 0; err_seen = 0;
        VECTOR_WIDTH = vw; NUM_VECTORS = nv; START = 1'b1;
        step();
        START = 1'b0;
        for (int c = 1; c <= 400 && cyc_done == 0; c++) begin
            if (EN_Acc) accs++;
            if (EN_Acc && !RST_Acc) begin
                wa_n++;
                if (RDY_Acc) begin
                    addrs.push_back(16'(ADDR_RAM));
                    ens.push_back(EN_Pipe);
                end
            end
            if (WE_RES) wrs.push_back(int'(ADDR_RES));
            if (ERR) err_seen = 1'b1;
            if (DONE) cyc_done = c;
            START = pert && c == 3;
            if (pert && c >= 2) begin
                VECTOR_WIDTH = 8'd5;
                NUM_VECTORS  = 8'd9;
            end
            if (cyc_done == 0) step();
        end
        START = 1'b0;
        if (cyc_done == 0) chk("done_timeout", 0, 1);
    endtask
    task automatic chk_40x1(input string tag);
        ea = '{16'd0, 16'd16, 16'd32};
        ee = '{16'hFFFF, 16'hFFFF, 16'h00FF};
        chk({tag, "_nchunks"}, 32'(addrs.size()), 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), i < addrs.size() ? 32'(addrs[i]) : 'x, 32'(ea[i]));
            chk($sformatf("%s_en%0d", tag, i), i < ens.size() ? 32'(ens[i]) : 'x, 32'(ee[i]));
        end
        chk({tag, "_nwr"}, 32'(wrs.size()), 1);
        chk({tag, "_wr0"}, wrs.size() > 0 ? 32'(wrs[0]) : 'x, 0);
        chk({tag, "_cycles"}, 32'(cyc_done), 9);
        step();
        chk({tag, "_done_once"}, 32'(DONE), 0);
        chk({tag, "_busy_fall"}, 32'(BUSY), 0);
    endtask
    initial begin
        RST = 1'b1; START = 1'b0; RDY_Acc = 1'b1; RDY_Sqrt = 1'b1;
        VECTOR_WIDTH = '0; NUM_VECTORS = '0;
        step(); step();
        RST = 1'b0;
        chk_idle("reset");
        chk("reset_err", 32'(ERR), 0);
        // 40 elements, one vector: chunks of 16, 16, 8
        run(8'd40, 8'd1, 1'b0);
        chk_40x1("v40");
        // three single-chunk vectors
        run(8'd16, 8'd3, 1'b0);
        ea = '{16'd0, 16'd16, 16'd32};
        chk("v16_nchunks", 32'(addrs.size()), 3);
        chk("v16_nwr", 32'(wrs.size()), 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("v16_addr%0d", i), i < addrs.size() ? 32'(addrs[i]) : 'x, 32'(ea[i]));
            chk($sformatf("v16_en%0d", i), i < ens.size() ? 32'(ens[i]) : 'x, 32'hFFFF);
            chk($sformatf("v16_wr%0d", i), i < wrs.size() ? 32'(wrs[i]) : 'x, 32'(i));
        end
        chk("v16_wacc", 32'(wa_n), 3);
        chk("v16_cycles", 32'(cyc_done), 13);
        step();
        chk("v16_done_once", 32'(DONE), 0);
        chk_idle("v16_after");
        // degenerate batches
        run(8'd0, 8'd5, 1'b0);
        chk("vw0_cycles", 32'(cyc_done), 1);
        chk("vw0_acc", 32'(accs), 0);
        chk("vw0_nwr", 32'(wrs.size()), 0);
        step();
        chk("vw0_busy", 32'(BUSY), 0);
        run(8'd7, 8'd0, 1'b0);
        chk("nv0_cycles", 32'(cyc_done), 1);
        chk("nv0_acc", 32'(accs), 0);
        chk("nv0_nwr", 32'(wrs.size()), 0);
        step();
        chk("nv0_busy", 32'(BUSY), 0);
        // reset while waiting for sqrt on vector 1 of 3
        VECTOR_WIDTH = 8'd16; NUM_VECTORS = 8'd3; START = 1'b1;
        step();
        START = 1'b0;
        for (int c = 0; c < 20 && !WE_RES; c++) step();
        chk("rst_first_wr", 32'(WE_RES), 1);
        RDY_Sqrt = 1'b0;
        for (int c = 0; c < 20 && !EN_Sqrt; c++) step();
        chk("rst_in_sqrt", 32'(EN_Sqrt), 1);
        RST = 1'b1;
        step();
        RST = 1'b0; RDY_Sqrt = 1'b1;
        chk_idle("rst_mid");
        step();
        chk("rst_no_done", 32'(DONE | WE_RES), 0);
        run(8'd16, 8'd1, 1'b0);
        chk("rst_restart_addr", addrs.size() > 0 ? 32'(addrs[0]) : 'x, 0);
        chk("rst_restart_wr", wrs.size() > 0 ? 32'(wrs[0]) : 'x, 0);
        step();
        // START retrigger and width change mid-batch must not disturb the sequence
        run(8'd40, 8'd1, 1'b1);
        chk_40x1("pert");
`ifdef DIST_TIMEOUT_EN
        RDY_Acc = 1'b0;
        run(8'd16, 8'd1, 1'b0);
        chk("tmo_wacc_cycles", 32'(wa_n), 255);
        chk("tmo_err", 32'(ERR), 1);
        chk("tmo_nwr", 32'(wrs.size()), 0);
        RDY_Acc = 1'b1;
        step();
        chk("tmo_err_sticky", 32'(ERR), 1);
        run(8'd16, 8'd1, 1'b0);
        chk("tmo_err_cleared", 32'(err_seen), 0);
        step();
`else
        chk("no_tmo_err", 32'(err_seen), 0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
